age_matrix_issue_select: RTL and testbench
==========================================

Name: age_matrix_issue_select

Overview:
- Parametrised successor to the reservation-station allocate/issue selector.
- Tracks occupancy of SIZE entries in registered valid bits and allocates the lowest-index free entry.
- Keeps exact relative age in a registered SIZE x SIZE age matrix, so age never saturates or wraps.
- Issues the oldest valid-and-ready entry through a valid/ready handshake; supports flush and reports occupancy.

Parameters:
- SIZE, 4, number of entries (>= 2).
- IDX_W, $clog2(SIZE), index width. Derived; never overridden.
- CNT_W, $clog2(SIZE+1), occupancy count width. Derived; never overridden.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  reset, synchronous, active-low (0 = reset).
- flush_i  input  1  clear all entries on next edge.
- alloc_valid_i  input  1  producer requests an entry this cycle.
- alloc_ready_o  output  1  at least one entry free.
- alloc_idx_o  output  IDX_W  lowest-index free entry; 0 when full.
- alloc_onehot_o  output  SIZE  one-hot of alloc_idx_o; all zero when full.
- entry_ready_i  input  SIZE  per-entry operands ready; ignored for invalid entries.
- issue_valid_o  output  1  a valid ready entry is selected.
- issue_ready_i  input  1  consumer accepts issue.
- issue_idx_o  output  IDX_W  selected entry; 0 when issue_valid_o=0.
- issue_onehot_o  output  SIZE  one-hot of issue_idx_o; all zero when issue_valid_o=0.
- entry_valid_o  output  SIZE  registered occupancy vector.
- count_o  output  CNT_W  number of valid entries (registered).

Behaviour:
- Reset (reset_i=0 at edge):
  - valid=0, age matrix=0, count_o=0.
  - Combinational outputs follow: alloc_ready_o=1, alloc_idx_o=0, issue_valid_o=0.
  - Reset overrides flush, alloc and issue.
- Age matrix: older[i][j]=1 means entry i is older than entry j. Only entries valid at the same time are compared.
- Allocation fires when alloc_valid_i & alloc_ready_o at the edge, with k=alloc_idx_o:
  - valid[k]<=1.
  - For every j valid before the edge and not issued this edge: older[j][k]<=1, older[k][j]<=0.
  - alloc_valid_i while full is ignored; no state change.
- Selection (combinational, zero latency):
  - cand[i] = valid[i] & entry_ready_i[i].
  - Select i when cand[i]=1 and no j!=i has cand[j]&older[j][i].
  - Exactly one candidate qualifies. The matrix is a total order over valid entries.
  - Selection may change cycle to cycle while not accepted; no hold requirement.
- Issue fires when issue_valid_o & issue_ready_i at the edge: valid[sel]<=0. Its matrix row and column become don't-care and are overwritten on reallocation.
- Simultaneous alloc and issue in one cycle:
  - Both take effect.
  - Allocation uses the pre-edge free vector, so an entry issued this cycle is not reallocated until the next cycle.
  - count_o unchanged.
- count_o is +1 on alloc only, -1 on issue only, and unchanged on both or neither. It equals popcount(valid) at all times.
- Flush (reset_i=1, flush_i=1):
  - valid<=0, count_o<=0.
  - Takes priority over alloc/issue in the same cycle; those handshakes are dropped even if outputs showed valid.
- Full: alloc_ready_o=0, alloc_onehot_o=0.
- Empty: issue_valid_o=0.
- Entries with entry_ready_i=1 but valid=0 are never selected.

Test Plan:
- SIZE=4, reset held 2 cycles then released:
  - count_o=0, alloc_idx_o=0, alloc_ready_o=1, issue_valid_o=0.
- Allocate 4 consecutive cycles with issue_ready_i=0 and entry_ready_i=0:
  - alloc_idx_o goes 0,1,2,3; count_o ends at 4; alloc_ready_o=0.
  - A 5th alloc_valid_i leaves count_o=4.
- From full, set entry_ready_i=4'b1110:
  - issue_idx_o=1, matching the oldest ready entry (allocation order 0,1,2,3).
  - Accept -> entry_valid_o=4'b1101.
  - Next selection with the same readiness is 2.
- Age beats index: from the previous state, allocate into freed entry 1, then set entry_ready_i=4'b0011:
  - issue_idx_o=0 (entry 0 is the oldest).
  - After 0 issues, issue_idx_o=1.
  - With entry_ready_i=4'b1010, issue_idx_o=3, because entry 3 is older than the reallocated entry 1.
- Simultaneous alloc and issue at count_o=3 with entry 2 free and entry 0 issuing:
  - Allocation goes to entry 2, not entry 0; count_o stays 3.
  - Next cycle alloc_idx_o=0.
- Assert flush_i together with alloc_valid_i and issue_ready_i:
  - Next cycle entry_valid_o=0, count_o=0, issue_valid_o=0.
  - reset_i=0 mid-stream gives the same result, and reset wins when flush_i=1 simultaneously.

Source files
------------

// File: rtl/age_matrix_issue_select.sv
// Reservation-station allocate/issue selector.
// Exact relative age kept in a SIZE x SIZE matrix; oldest ready entry issues.
module age_matrix_issue_select #(
  parameter int SIZE  = 4,
  parameter int IDX_W = $clog2(SIZE),
  parameter int CNT_W = $clog2(SIZE+1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             alloc_valid_i,
  output logic             alloc_ready_o,
  output logic [IDX_W-1:0] alloc_idx_o,
  output logic [SIZE-1:0]  alloc_onehot_o,
  input  logic [SIZE-1:0]  entry_ready_i,
  output logic             issue_valid_o,
  input  logic             issue_ready_i,
  output logic [IDX_W-1:0] issue_idx_o,
  output logic [SIZE-1:0]  issue_onehot_o,
  output logic [SIZE-1:0]  entry_valid_o,
  output logic [CNT_W-1:0] count_o
);

  logic [SIZE-1:0]            valid_q, valid_d;
  logic [SIZE-1:0][SIZE-1:0]  older_q, older_d;
  logic [CNT_W-1:0]           count_q, count_d;

  logic [SIZE-1:0] free;
  logic [SIZE-1:0] cand;
  logic [SIZE-1:0] blocked;
  logic [SIZE-1:0] issue_clr;
  logic [SIZE-1:0] alloc_set;
  logic [SIZE-1:0] survivors;
  logic            alloc_fire;
  logic            issue_fire;

  assign free           = ~valid_q;
  assign alloc_ready_o  = |free;
  assign alloc_onehot_o = free & (~free + SIZE'(1));

  always_comb begin
    alloc_idx_o = '0;
    for (int i = SIZE-1; i >= 0; i--) begin
      if (free[i]) alloc_idx_o = IDX_W'(i);
    end
  end

  assign cand = valid_q & entry_ready_i;

  // Entry i is blocked by any older candidate j.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        if (j != i && cand[j] && older_q[j][i]) blocked[i] = 1'b1;
      end
    end
  end

  assign issue_onehot_o = cand & ~blocked;
  assign issue_valid_o  = |cand;

  always_comb begin
    issue_idx_o = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (issue_onehot_o[i]) issue_idx_o = issue_idx_o | IDX_W'(i);
    end
  end

  assign alloc_fire = alloc_valid_i & alloc_ready_o;
  assign issue_fire = issue_valid_o & issue_ready_i;
  assign issue_clr  = issue_fire ? issue_onehot_o : '0;
  assign alloc_set  = alloc_fire ? alloc_onehot_o : '0;
  assign survivors  = valid_q & ~issue_clr;
  assign valid_d    = survivors | alloc_set;

  always_comb begin
    older_d = older_q;
    for (int k = 0; k < SIZE; k++) begin
      if (alloc_set[k]) begin
        for (int j = 0; j < SIZE; j++) begin
          if (survivors[j]) begin
            older_d[j][k] = 1'b1;
            older_d[k][j] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    case ({alloc_fire, issue_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      valid_q <= '0;
      older_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      older_q <= older_d;
      count_q <= count_d;
    end
  end

  assign entry_valid_o = valid_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_age_matrix_issue_select.sv
// Directed bench for age_matrix_issue_select.
// Each task drives one scenario and checks against hand-computed values.
module tb_age_matrix_issue_select;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       flush_i;
  logic       alloc_valid_i;
  logic       alloc_ready_o;
  logic [1:0] alloc_idx_o;
  logic [3:0] alloc_onehot_o;
  logic [3:0] entry_ready_i;
  logic       issue_valid_o;
  logic       issue_ready_i;
  logic [1:0] issue_idx_o;
  logic [3:0] issue_onehot_o;
  logic [3:0] entry_valid_o;
  logic [2:0] count_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk_i = ~clk_i;

  age_matrix_issue_select #(.SIZE(4)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .flush_i        (flush_i),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_ready_o  (alloc_ready_o),
    .alloc_idx_o    (alloc_idx_o),
    .alloc_onehot_o (alloc_onehot_o),
    .entry_ready_i  (entry_ready_i),
    .issue_valid_o  (issue_valid_o),
    .issue_ready_i  (issue_ready_i),
    .issue_idx_o    (issue_idx_o),
    .issue_onehot_o (issue_onehot_o),
    .entry_valid_o  (entry_valid_o),
    .count_o        (count_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i       = 1'b0;
    alloc_valid_i = 1'b0;
    issue_ready_i = 1'b0;
    entry_ready_i = 4'b0000;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    idle();
    step();
    step();
    reset_i = 1'b1;
    #1;
    chk_cnt++;
    if (count_o !== 3'd0)
      $display("FAIL reset_count got %0d want 0", count_o);
    else pass_cnt++;
    chk_cnt++;
    if (alloc_idx_o !== 2'd0)
      $display("FAIL reset_alloc_idx got %0d want 0", alloc_idx_o);
    else pass_cnt++;
    chk_cnt++;
    if (alloc_ready_o !== 1'b1)
      $display("FAIL reset_alloc_ready got %0b want 1", alloc_ready_o);
    else pass_cnt++;
    chk_cnt++;
    if (issue_valid_o !== 1'b0)
      $display("FAIL reset_issue_valid got %0b want 0", issue_valid_o);
    else pass_cnt++;
    chk_cnt++;
    if (entry_valid_o !== 4'b0000)
      $display("FAIL reset_valid got %b want 0000", entry_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    logic [3:0] exp_oh;
    alloc_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_oh = 4'b0001 << k;
      chk_cnt++;
      if (alloc_idx_o !== 2'(k) || alloc_onehot_o !== exp_oh)
        $display("FAIL fill_idx%0d got %0d/%b want %0d/%b",
                 k, alloc_idx_o, alloc_onehot_o, k, exp_oh);
      else pass_cnt++;
      step();
    end
    chk_cnt++;
    if (count_o !== 3'd4)
      $display("FAIL fill_count got %0d want 4", count_o);
    else pass_cnt++;
    chk_cnt++;
    if (alloc_ready_o !== 1'b0 || alloc_onehot_o !== 4'b0000 ||
        alloc_idx_o !== 2'd0)
      $display("FAIL full_alloc got rdy=%0b oh=%b idx=%0d want 0/0000/0",
               alloc_ready_o, alloc_onehot_o, alloc_idx_o);
    else pass_cnt++;
    step();
    alloc_valid_i = 1'b0;
    chk_cnt++;
    if (count_o !== 3'd4 || entry_valid_o !== 4'b1111)
      $display("FAIL alloc_when_full got %0d/%b want 4/1111",
               count_o, entry_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_oldest();
    entry_ready_i = 4'b1110;
    #1;
    chk_cnt++;
    if (issue_valid_o !== 1'b1 || issue_idx_o !== 2'd1 ||
        issue_onehot_o !== 4'b0010)
      $display("FAIL oldest_sel got v=%0b idx=%0d oh=%b want 1/1/0010",
               issue_valid_o, issue_idx_o, issue_onehot_o);
    else pass_cnt++;
    issue_ready_i = 1'b1;
    step();
    issue_ready_i = 1'b0;
    #1;
    chk_cnt++;
    if (entry_valid_o !== 4'b1101 || count_o !== 3'd3)
      $display("FAIL issue_clear got %b/%0d want 1101/3",
               entry_valid_o, count_o);
    else pass_cnt++;
    chk_cnt++;
    if (issue_idx_o !== 2'd2)
      $display("FAIL next_sel got %0d want 2", issue_idx_o);
    else pass_cnt++;
  endtask

  task automatic test_age_beats_index();
    entry_ready_i = 4'b0000;
    alloc_valid_i = 1'b1;
    #1;
    chk_cnt++;
    if (alloc_idx_o !== 2'd1)
      $display("FAIL realloc_idx got %0d want 1", alloc_idx_o);
    else pass_cnt++;
    step();
    alloc_valid_i = 1'b0;
    entry_ready_i = 4'b0011;
    #1;
    chk_cnt++;
    if (issue_idx_o !== 2'd0)
      $display("FAIL age_sel0 got %0d want 0", issue_idx_o);
    else pass_cnt++;
    issue_ready_i = 1'b1;
    step();
    issue_ready_i = 1'b0;
    #1;
    chk_cnt++;
    if (issue_idx_o !== 2'd1 || entry_valid_o !== 4'b1110)
      $display("FAIL age_sel1 got %0d/%b want 1/1110",
               issue_idx_o, entry_valid_o);
    else pass_cnt++;
    entry_ready_i = 4'b1010;
    #1;
    chk_cnt++;
    if (issue_idx_o !== 2'd3 || issue_onehot_o !== 4'b1000)
      $display("FAIL age_sel3 got %0d/%b want 3/1000",
               issue_idx_o, issue_onehot_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // valid 1110, age 2,3,1: issue 2 then refill entry 0
    entry_ready_i = 4'b0100;
    issue_ready_i = 1'b1;
    step();
    issue_ready_i = 1'b0;
    entry_ready_i = 4'b0000;
    alloc_valid_i = 1'b1;
    step();
    alloc_valid_i = 1'b0;
    #1;
    chk_cnt++;
    if (entry_valid_o !== 4'b1011 || count_o !== 3'd3)
      $display("FAIL setup_simul got %b/%0d want 1011/3",
               entry_valid_o, count_o);
    else pass_cnt++;
    entry_ready_i = 4'b0001;
    alloc_valid_i = 1'b1;
    issue_ready_i = 1'b1;
    #1;
    chk_cnt++;
    if (alloc_idx_o !== 2'd2 || issue_idx_o !== 2'd0)
      $display("FAIL simul_pre got a=%0d i=%0d want 2/0",
               alloc_idx_o, issue_idx_o);
    else pass_cnt++;
    step();
    alloc_valid_i = 1'b0;
    issue_ready_i = 1'b0;
    entry_ready_i = 4'b0110;
    #1;
    chk_cnt++;
    if (entry_valid_o !== 4'b1110 || count_o !== 3'd3)
      $display("FAIL simul_post got %b/%0d want 1110/3",
               entry_valid_o, count_o);
    else pass_cnt++;
    chk_cnt++;
    if (alloc_idx_o !== 2'd0)
      $display("FAIL simul_next_alloc got %0d want 0", alloc_idx_o);
    else pass_cnt++;
    chk_cnt++;
    if (issue_idx_o !== 2'd1)
      $display("FAIL simul_age got %0d want 1", issue_idx_o);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    flush_i       = 1'b1;
    alloc_valid_i = 1'b1;
    issue_ready_i = 1'b1;
    entry_ready_i = 4'b1111;
    step();
    idle();
    entry_ready_i = 4'b1111;
    #1;
    chk_cnt++;
    if (entry_valid_o !== 4'b0000 || count_o !== 3'd0 ||
        issue_valid_o !== 1'b0)
      $display("FAIL flush got %b/%0d/%0b want 0000/0/0",
               entry_valid_o, count_o, issue_valid_o);
    else pass_cnt++;
    entry_ready_i = 4'b0000;
    alloc_valid_i = 1'b1;
    step();
    step();
    alloc_valid_i = 1'b0;
    entry_ready_i = 4'b0011;
    #1;
    chk_cnt++;
    if (entry_valid_o !== 4'b0011 || count_o !== 3'd2 ||
        issue_idx_o !== 2'd0)
      $display("FAIL refill got %b/%0d/%0d want 0011/2/0",
               entry_valid_o, count_o, issue_idx_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    reset_i       = 1'b0;
    alloc_valid_i = 1'b1;
    issue_ready_i = 1'b1;
    entry_ready_i = 4'b1111;
    step();
    reset_i = 1'b1;
    idle();
    #1;
    chk_cnt++;
    if (entry_valid_o !== 4'b0000 || count_o !== 3'd0 ||
        issue_valid_o !== 1'b0)
      $display("FAIL mid_reset got %b/%0d/%0b want 0000/0/0",
               entry_valid_o, count_o, issue_valid_o);
    else pass_cnt++;
    alloc_valid_i = 1'b1;
    step();
    step();
    reset_i       = 1'b0;
    flush_i       = 1'b1;
    issue_ready_i = 1'b1;
    entry_ready_i = 4'b1111;
    step();
    reset_i = 1'b1;
    idle();
    entry_ready_i = 4'b1111;
    #1;
    chk_cnt++;
    if (entry_valid_o !== 4'b0000 || count_o !== 3'd0 ||
        issue_valid_o !== 1'b0 || alloc_idx_o !== 2'd0)
      $display("FAIL reset_flush got %b/%0d/%0b/%0d want 0000/0/0/0",
               entry_valid_o, count_o, issue_valid_o, alloc_idx_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_oldest();
    test_age_beats_index();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
